vc_input_buffer_6vc: RTL and testbench
======================================

Name: vc_input_buffer_6vc

Overview:
- Receive side of the 6-VC link: one incoming flit per cycle, steered by a one-hot VC select into one of six per-VC FIFOs.
- Presents each VC's head flit and valid to the VC allocator / output mux stage.
- Returns one credit pulse per VC each time a flit is dequeued, closing credit-based flow control with the upstream router.

Parameters:
- DEPTH, 4, flits per VC FIFO; power of two, 2..16.
- PTR_W, $clog2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  `DW  incoming flit.
- valid_in  input  1  data_in valid this cycle.
- vc_sel  input  6  one-hot target VC for data_in; bit i = VC i.
- data_out_vc0..data_out_vc5  output  `DW each  head flit of VC i; 0 when VC i is empty.
- valid_out  output  6  bit i = VC i non-empty.
- read_in  input  6  bit i pops VC i head this cycle.
- credit_out  output  6  registered one-cycle pulse per VC pop, to upstream.
- err_sel  output  1  sticky: valid_in seen with non-one-hot vc_sel.
- err_ovf  output  1  sticky: write to a full VC dropped.

Behaviour:
- Reset (rst=1 at rising edge): all rd/wr pointers and counts = 0; valid_out = 0; credit_out = 0; err_sel = 0; err_ovf = 0; all data_out_vci = 0. Storage contents are not reset.
- Per-VC state: wr_ptr, rd_ptr (PTR_W bits, wrap DEPTH-1 -> 0); count (PTR_W+1 bits, 0..DEPTH).
- Write:
  - When valid_in=1 and vc_sel is one of the six one-hot codes, data_in is stored at wr_ptr of that VC on the edge.
  - wr_ptr++ and count++ unless the write is dropped.
- Bad select: valid_in=1 with vc_sel = 0 or more than one bit set -> flit dropped, no state change, err_sel set to 1.
- Dropped write (full VC): VC count == DEPTH with no simultaneous pop of that VC -> flit dropped, err_ovf set to 1.
- Full with same-cycle pop: the write is accepted and count stays DEPTH.
- Read:
  - read_in[i]=1 with valid_out[i]=1 pops VC i: rd_ptr++ and count-- on the edge.
  - read_in[i]=1 with VC i empty is ignored: no credit, no error.
- Simultaneous write and pop on the same VC: count unchanged, both pointers advance.
- Pops on different VCs in the same cycle are independent; all six may pop at once.
- Output timing:
  - valid_out[i] = (count_i != 0), driven from registered state.
  - data_out_vci = storage[rd_ptr_i] when non-empty, else 0 (combinational read of registered storage, first-word fall-through).
  - Write-to-valid latency is 1 cycle: flit written at edge N appears on data_out/valid_out after edge N.
- Write into an empty VC while its read_in is high: no pop that cycle, because valid_out was 0 at the edge.
- credit_out[i]:
  - Asserted for exactly one cycle, on the cycle after the edge where VC i popped.
  - Back-to-back pops give back-to-back pulses.
  - Credits count only accepted pops.
- Sticky errors are cleared only by rst.
- Reset mid-operation: all queued flits are discarded (counts = 0). Pending credit pulses are suppressed and not re-issued. Upstream is expected to reset its credit counters with the same rst.

Test Plan:
- Reset then idle: rst high 2 cycles -> valid_out=6'b000000, credit_out=0, data_out_vc0..5=0, err flags 0.
- Single flit: data_in=32'hA5A5_0001, vc_sel=6'b000100, valid_in=1 for one cycle -> next cycle valid_out=6'b000100 and data_out_vc2=32'hA5A5_0001. Then read_in=6'b000100 for one cycle -> valid_out=0, and credit_out=6'b000100 for exactly one cycle.
- Fill and overflow: write 5 flits (values 1..5) to VC0 with DEPTH=4 and no reads -> valid_out[0]=1, err_ovf=1 after the 5th edge. Then pop 4 times -> data_out_vc0 sequence 1,2,3,4, four credit pulses on bit 0, then VC0 empty.
- Full with simultaneous pop: VC3 full holding 10..13; write 14 to VC3 with read_in[3]=1 -> err_ovf stays 0, count stays 4. Subsequent pops return 11,12,13,14.
- Bad select and parallel VCs: valid_in=1 with vc_sel=6'b000011 -> nothing written, err_sel=1. Next, one flit each to VC1 and VC5 on successive cycles, then read_in=6'b100010 in one cycle -> both pop, credit_out=6'b100010 for one cycle.
- Reset mid-traffic: VC4 holds 3 flits and a pop occurs on the same edge as rst=1 -> after reset valid_out=0, credit_out stays 0, and a new write to VC4 is read back correctly as the only flit.

Source files
------------

// File: rtl/vc_input_buffer_6vc.sv
// Receive-side input buffer for a 6-VC link: one-hot steered writes into six
// first-word-fall-through FIFOs, with per-VC head outputs and credit returns.
module vc_input_buffer_6vc #(
  parameter  int DEPTH = 4,
  parameter  int DW    = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] data_in,
  input  logic          valid_in,
  input  logic [5:0]    vc_sel,
  output logic [DW-1:0] data_out_vc0,
  output logic [DW-1:0] data_out_vc1,
  output logic [DW-1:0] data_out_vc2,
  output logic [DW-1:0] data_out_vc3,
  output logic [DW-1:0] data_out_vc4,
  output logic [DW-1:0] data_out_vc5,
  output logic [5:0]    valid_out,
  input  logic [5:0]    read_in,
  output logic [5:0]    credit_out,
  output logic          err_sel,
  output logic          err_ovf
);

  localparam int             NVC  = 6;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q [NVC];
  logic [PTR_W-1:0] wr_ptr_d [NVC];
  logic [PTR_W-1:0] rd_ptr_q [NVC];
  logic [PTR_W-1:0] rd_ptr_d [NVC];
  logic [PTR_W:0]   count_q  [NVC];
  logic [PTR_W:0]   count_d  [NVC];
  logic [5:0]       credit_q, credit_d;
  logic             err_sel_q, err_sel_d;
  logic             err_ovf_q, err_ovf_d;
  logic [DW-1:0]    mem_q    [NVC][DEPTH];
  logic [DW-1:0]    head     [NVC];
  logic             sel_onehot;
  logic [5:0]       push_req, push, pop;

  assign sel_onehot = (vc_sel != '0) && ((vc_sel & (vc_sel - 6'd1)) == '0);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    push_req = '0;
    push     = '0;
    pop      = '0;
    for (int i = 0; i < NVC; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      pop[i]      = read_in[i] && (count_q[i] != '0);
      push_req[i] = valid_in && sel_onehot && vc_sel[i];
      // A full VC still accepts a write when its head leaves on the same edge.
      push[i]     = push_req[i] && ((count_q[i] != FULL) || pop[i]);
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      if (push[i] && !pop[i])      count_d[i] = count_q[i] + (PTR_W+1)'(1);
      else if (!push[i] && pop[i]) count_d[i] = count_q[i] - (PTR_W+1)'(1);
    end
    credit_d  = pop;
    err_sel_d = err_sel_q | (valid_in & ~sel_onehot);
    err_ovf_d = err_ovf_q | (|(push_req & ~push));
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NVC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      credit_q  <= '0;
      err_sel_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      for (int i = 0; i < NVC; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        count_q[i]  <= count_d[i];
      end
      credit_q  <= credit_d;
      err_sel_q <= err_sel_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  // NOTE: flit storage has no reset; emptiness is tracked by count_q alone,
  // so stale contents are never visible on the outputs.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NVC; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= data_in;
    end
  end

  always_comb begin
    valid_out = '0;
    for (int i = 0; i < NVC; i++) begin
      valid_out[i] = (count_q[i] != '0);
      head[i]      = valid_out[i] ? mem_q[i][rd_ptr_q[i]] : '0;
    end
  end

  assign data_out_vc0 = head[0];
  assign data_out_vc1 = head[1];
  assign data_out_vc2 = head[2];
  assign data_out_vc3 = head[3];
  assign data_out_vc4 = head[4];
  assign data_out_vc5 = head[5];
  assign credit_out   = credit_q;
  assign err_sel      = err_sel_q;
  assign err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_vc_input_buffer_6vc.sv
// Bench for vc_input_buffer_6vc: directed scenarios plus random traffic against
// per-VC queue model; popped flits are checked by an independent monitor.
module tb_vc_input_buffer_6vc;

  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic [5:0]    vc_sel;
  logic [DW-1:0] data_out_vc0, data_out_vc1, data_out_vc2;
  logic [DW-1:0] data_out_vc3, data_out_vc4, data_out_vc5;
  logic [5:0]    valid_out;
  logic [5:0]    read_in;
  logic [5:0]    credit_out;
  logic          err_sel;
  logic          err_ovf;

  vc_input_buffer_6vc #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .vc_sel(vc_sel),
    .data_out_vc0(data_out_vc0), .data_out_vc1(data_out_vc1), .data_out_vc2(data_out_vc2),
    .data_out_vc3(data_out_vc3), .data_out_vc4(data_out_vc4), .data_out_vc5(data_out_vc5),
    .valid_out(valid_out), .read_in(read_in), .credit_out(credit_out),
    .err_sel(err_sel), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] dout [6];
  assign dout[0] = data_out_vc0;
  assign dout[1] = data_out_vc1;
  assign dout[2] = data_out_vc2;
  assign dout[3] = data_out_vc3;
  assign dout[4] = data_out_vc4;
  assign dout[5] = data_out_vc5;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: contents of each VC, plus the scoreboard of flits the
  // monitor expects to see leave each VC, in order.
  logic [DW-1:0] mdl [6][$];
  logic [DW-1:0] sb  [6][$];
  logic [5:0]    exp_credit = '0;
  logic          exp_sel    = 1'b0;
  logic          exp_ovf    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever the DUT is about to pop a VC, its head must be the
  // oldest flit the stimulus issued to that VC.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (valid_out[i] === 1'b1 && read_in[i] === 1'b1) begin
          if (sb[i].size() == 0) check($sformatf("pop_vc%0d_expected", i), 32'd1, 32'd0);
          else check($sformatf("pop_vc%0d_data", i), dout[i], sb[i].pop_front());
        end
      end
    end
  end

  task automatic verify();
    logic [5:0] exp_valid;
    exp_valid = '0;
    for (int i = 0; i < 6; i++) begin
      exp_valid[i] = (mdl[i].size() != 0);
      if (mdl[i].size() == 0) check($sformatf("empty_data_vc%0d", i), dout[i], 32'd0);
    end
    check("valid_out", {26'd0, valid_out}, {26'd0, exp_valid});
    check("credit_out", {26'd0, credit_out}, {26'd0, exp_credit});
    check("err_sel", {31'd0, err_sel}, {31'd0, exp_sel});
    check("err_ovf", {31'd0, err_ovf}, {31'd0, exp_ovf});
  endtask

  // Drives one cycle (called just after a rising edge), advances the model by
  // the rules for the coming edge, then checks the registered results.
  task automatic step(input logic r, input logic vi, input logic [5:0] sel,
                      input logic [DW-1:0] d, input logic [5:0] rd);
    logic [5:0] pops;
    int         v;
    bit         accept;
    rst = r; valid_in = vi; vc_sel = sel; data_in = d; read_in = rd;
    pops = '0;
    v = -1;
    for (int i = 0; i < 6; i++) begin
      if (rd[i] && mdl[i].size() != 0) pops[i] = 1'b1;
      if (sel[i]) v = i;
    end
    if (!r) begin
      accept = 1'b0;
      if (vi && $countones(sel) != 1) exp_sel = 1'b1;
      if (vi && $countones(sel) == 1) begin
        accept = (mdl[v].size() < DEPTH) || pops[v];
        if (!accept) exp_ovf = 1'b1;
      end
      for (int i = 0; i < 6; i++) if (pops[i]) void'(mdl[i].pop_front());
      if (accept) begin
        mdl[v].push_back(d);
        sb[v].push_back(d);
      end
      exp_credit = pops;
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 6; i++) begin
        mdl[i].delete();
        sb[i].delete();
      end
      exp_credit = '0;
      exp_sel    = 1'b0;
      exp_ovf    = 1'b0;
    end
    verify();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 6'd0, '0, 6'd0);
  endtask

  initial begin
    int total;
    rst = 1'b1; valid_in = 1'b0; vc_sel = '0; data_in = '0; read_in = '0;

    // Reset then idle
    step(1'b1, 1'b0, 6'd0, '0, 6'd0);
    step(1'b1, 1'b0, 6'd0, '0, 6'd0);
    check("reset_valid", {26'd0, valid_out}, 32'd0);
    idle();

    // Single flit into VC2, then pop it
    step(1'b0, 1'b1, 6'b000100, 32'hA5A5_0001, 6'd0);
    check("single_valid", {26'd0, valid_out}, 32'h4);
    check("single_data", data_out_vc2, 32'hA5A5_0001);
    step(1'b0, 1'b0, 6'd0, '0, 6'b000100);
    check("single_credit", {26'd0, credit_out}, 32'h4);
    idle();
    check("single_credit_gone", {26'd0, credit_out}, 32'h0);

    // Fill VC0 and overflow, then drain
    for (int k = 1; k <= 5; k++) step(1'b0, 1'b1, 6'b000001, 32'(k), 6'd0);
    check("ovf_flag", {31'd0, err_ovf}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 6'd0, '0, 6'b000001);
      check("ovf_drain_credit", {26'd0, credit_out}, 32'h1);
    end
    idle();
    check("ovf_drained", {26'd0, valid_out}, 32'd0);

    // Full VC3 with simultaneous pop and write
    step(1'b1, 1'b0, 6'd0, '0, 6'd0);
    for (int k = 10; k <= 13; k++) step(1'b0, 1'b1, 6'b001000, 32'(k), 6'd0);
    step(1'b0, 1'b1, 6'b001000, 32'd14, 6'b001000);
    check("full_pop_no_ovf", {31'd0, err_ovf}, 32'd0);
    check("full_pop_head", data_out_vc3, 32'd11);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 6'd0, '0, 6'b001000);
    idle();

    // Bad select, then parallel pops on VC1 and VC5
    step(1'b0, 1'b1, 6'b000011, 32'hDEAD_0000, 6'd0);
    check("bad_sel_flag", {31'd0, err_sel}, 32'd1);
    step(1'b0, 1'b1, 6'b000010, 32'h1111_0001, 6'd0);
    step(1'b0, 1'b1, 6'b100000, 32'h5555_0005, 6'd0);
    step(1'b0, 1'b0, 6'd0, '0, 6'b100010);
    check("parallel_credit", {26'd0, credit_out}, 32'h22);
    idle();

    // Reset mid-traffic with a pop on the reset edge
    step(1'b1, 1'b0, 6'd0, '0, 6'd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 6'b010000, 32'h4440 + 32'(k), 6'd0);
    step(1'b1, 1'b0, 6'd0, '0, 6'b010000);
    idle();
    check("rst_mid_credit", {26'd0, credit_out}, 32'h0);
    step(1'b0, 1'b1, 6'b010000, 32'hBEEF_0004, 6'd0);
    check("rst_mid_head", data_out_vc4, 32'hBEEF_0004);
    step(1'b0, 1'b0, 6'd0, '0, 6'b010000);
    idle();

    // Random traffic: light reads first (fills and overflows), then heavy reads
    for (int c = 0; c < 1600; c++) begin
      logic          r;
      logic [5:0]    sel;
      logic [5:0]    rd;
      r   = ($urandom_range(0, 399) == 0);
      sel = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5));
      rd  = (c < 800) ? 6'($urandom & $urandom & $urandom) : 6'($urandom | $urandom);
      step(r, ($urandom_range(0, 3) != 0), sel, $urandom, rd);
    end

    for (int k = 0; k <= DEPTH; k++) step(1'b0, 1'b0, 6'd0, '0, 6'h3f);
    idle();
    total = 0;
    for (int i = 0; i < 6; i++) total += sb[i].size();
    check("scoreboard_drained", 32'(total), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
